hls_fp17_add_chn_b_skid_buf: RTL and testbench

- Two-entry registered skid buffer for the chn_b operand of the fp17 adder.
- Sits directly upstream of the core's chn_b rsci wait-control logic.
- Accepts 17-bit operands from the producer over a valid/ready handshake and presents them to the core as chn_b_rsci_vd plus data.
- Fully registers the ready path, so the core's stall logic has no combinational route back to the producer.

---
 rtl/hls_fp17_add_chn_b_skid_buf_if.sv | 50 +++++
 rtl/hls_fp17_add_chn_b_skid_buf.sv | 123 ++++++++++++
 tb/tb_hls_fp17_add_chn_b_skid_buf.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_fp17_add_chn_b_skid_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : hls_fp17_add_chn_b_skid_buf_if
// Brief    : chn_b producer/core handshake bundle for the fp17 adder skid buffer.
//            chn_b_bp_cnt exists only with HLS_FP17_ADD_CHN_B_BP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface hls_fp17_add_chn_b_skid_buf_if #(
    parameter int WIDTH = 17
);
    logic             chn_b_in_pvld;
    logic             chn_b_in_prdy;
    logic [WIDTH-1:0] chn_b_in_pd;
    logic             chn_b_rsci_vd;
    logic [WIDTH-1:0] chn_b_rsci_d;
    logic             chn_b_rsci_ld;
    logic             chn_b_clr;
`ifdef HLS_FP17_ADD_CHN_B_BP_CNT_EN
    logic [15:0]      chn_b_bp_cnt;
`endif

    // Buffer side
    modport slave (
        input  chn_b_in_pvld,
        output chn_b_in_prdy,
        input  chn_b_in_pd,
        output chn_b_rsci_vd,
        output chn_b_rsci_d,
        input  chn_b_rsci_ld,
`ifdef HLS_FP17_ADD_CHN_B_BP_CNT_EN
        output chn_b_bp_cnt,
`endif
        input  chn_b_clr
    );

    // Producer/core side
    modport master (
        output chn_b_in_pvld,
        input  chn_b_in_prdy,
        output chn_b_in_pd,
        input  chn_b_rsci_vd,
        input  chn_b_rsci_d,
        output chn_b_rsci_ld,
`ifdef HLS_FP17_ADD_CHN_B_BP_CNT_EN
        input  chn_b_bp_cnt,
`endif
        output chn_b_clr
    );
endinterface
`default_nettype wire

// File: rtl/hls_fp17_add_chn_b_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : hls_fp17_add_chn_b_skid_buf
// Brief    : Two-entry registered skid buffer for the fp17 adder chn_b operand.
//            Optional back-pressure counter: HLS_FP17_ADD_CHN_B_BP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hls_fp17_add_chn_b_skid_buf #(
    parameter int WIDTH = 17
) (
    input  wire logic                      nvdla_core_clk,
    input  wire logic                      nvdla_core_rstn,
    hls_fp17_add_chn_b_skid_buf_if.slave   chn_b
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_vd;
    logic             r_prdy;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;

    logic             w_push;
    logic             w_pop;
    logic             w_head_ld;
    logic             w_head_from_skid;
    logic             w_skid_ld;

    assign w_push = chn_b.chn_b_in_pvld & r_prdy;
    assign w_pop  = r_vd & chn_b.chn_b_rsci_ld;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (chn_b.chn_b_clr) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = S_FULL;
                    else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (w_pop) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Data-path load controls; flush suppresses every load.
    always_comb begin
        w_head_ld        = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        if (!chn_b.chn_b_clr) begin
            case (r_state)
                S_EMPTY: w_head_ld = w_push;
                S_ONE: begin
                    w_head_ld = w_push & w_pop;
                    w_skid_ld = w_push & ~w_pop;
                end
                S_FULL: begin
                    w_head_ld        = w_pop;
                    w_head_from_skid = w_pop;
                end
                default: ;
            endcase
        end
    end

    // vd and prdy are flops loaded from next state, so neither ld nor pvld
    // reaches prdy combinationally.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_vd   <= 1'b0;
            r_prdy <= 1'b0;
            r_head <= '0;
            r_skid <= '0;
        end else begin
            r_vd   <= (w_state_nxt != S_EMPTY);
            r_prdy <= (w_state_nxt != S_FULL);
            if (w_head_ld) begin
                r_head <= w_head_from_skid ? r_skid : chn_b.chn_b_in_pd;
            end
            if (w_skid_ld) begin
                r_skid <= chn_b.chn_b_in_pd;
            end
        end
    end

    assign chn_b.chn_b_in_prdy = r_prdy;
    assign chn_b.chn_b_rsci_vd = r_vd;
    assign chn_b.chn_b_rsci_d  = r_head;

`ifdef HLS_FP17_ADD_CHN_B_BP_CNT_EN
    logic [15:0] r_bp_cnt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_bp_cnt <= '0;
        end else if (chn_b.chn_b_clr) begin
            r_bp_cnt <= '0;
        end else if (r_vd && !chn_b.chn_b_rsci_ld && (r_bp_cnt != 16'hFFFF)) begin
            r_bp_cnt <= r_bp_cnt + 16'd1;
        end
    end

    assign chn_b.chn_b_bp_cnt = r_bp_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hls_fp17_add_chn_b_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_hls_fp17_add_chn_b_skid_buf
// Brief    : Directed self-checking bench for the chn_b skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hls_fp17_add_chn_b_skid_buf;

    localparam int WIDTH = 17;

    logic nvdla_core_clk;
    logic nvdla_core_rstn;
    int   n_cmp;
    int   n_fail;

    hls_fp17_add_chn_b_skid_buf_if #(.WIDTH(WIDTH)) bif ();

    hls_fp17_add_chn_b_skid_buf #(.WIDTH(WIDTH)) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .chn_b           (bif.slave)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Advance one edge and settle outputs before sampling/driving.
    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic drive(input logic pvld, input logic [WIDTH-1:0] pd,
                         input logic ld, input logic clr);
        bif.chn_b_in_pvld = pvld;
        bif.chn_b_in_pd   = pd;
        bif.chn_b_rsci_ld = ld;
        bif.chn_b_clr     = clr;
    endtask

    task automatic test_reset();
        nvdla_core_rstn = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0) begin
            $display("FAIL reset_vd: got %b expected 0", bif.chn_b_rsci_vd); n_fail++;
        end
        n_cmp++;
        if (bif.chn_b_in_prdy !== 1'b0) begin
            $display("FAIL reset_prdy: got %b expected 0", bif.chn_b_in_prdy); n_fail++;
        end
        n_cmp++;
        if (bif.chn_b_rsci_d !== 17'h00000) begin
            $display("FAIL reset_d: got %h expected 00000", bif.chn_b_rsci_d); n_fail++;
        end
        nvdla_core_rstn = 1'b1;
        step();
        n_cmp++;
        if (bif.chn_b_in_prdy !== 1'b1) begin
            $display("FAIL idle_prdy: got %b expected 1", bif.chn_b_in_prdy); n_fail++;
        end
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0) begin
            $display("FAIL idle_vd: got %b expected 0", bif.chn_b_rsci_vd); n_fail++;
        end
`ifdef HLS_FP17_ADD_CHN_B_BP_CNT_EN
        n_cmp++;
        if (bif.chn_b_bp_cnt !== 16'h0000) begin
            $display("FAIL idle_bp_cnt: got %h expected 0000", bif.chn_b_bp_cnt); n_fail++;
        end
`endif
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 17'(i), 1'b1, 1'b0);
            step();
            n_cmp++;
            if (bif.chn_b_rsci_vd !== 1'b1 || bif.chn_b_rsci_d !== 17'(i) ||
                bif.chn_b_in_prdy !== 1'b1) begin
                $display("FAIL stream_%0d: got vd=%b d=%h prdy=%b expected vd=1 d=%h prdy=1",
                         i, bif.chn_b_rsci_vd, bif.chn_b_rsci_d, bif.chn_b_in_prdy, 17'(i));
                n_fail++;
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0) begin
            $display("FAIL stream_drain: got vd=%b expected 0", bif.chn_b_rsci_vd); n_fail++;
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 17'h1AAAA, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b1 || bif.chn_b_rsci_d !== 17'h1AAAA ||
            bif.chn_b_in_prdy !== 1'b1) begin
            $display("FAIL bp_first: got vd=%b d=%h prdy=%b expected vd=1 d=1aaaa prdy=1",
                     bif.chn_b_rsci_vd, bif.chn_b_rsci_d, bif.chn_b_in_prdy);
            n_fail++;
        end
        drive(1'b1, 17'h05555, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b1 || bif.chn_b_rsci_d !== 17'h1AAAA ||
            bif.chn_b_in_prdy !== 1'b0) begin
            $display("FAIL bp_full: got vd=%b d=%h prdy=%b expected vd=1 d=1aaaa prdy=0",
                     bif.chn_b_rsci_vd, bif.chn_b_rsci_d, bif.chn_b_in_prdy);
            n_fail++;
        end
        // Offered word while full must be refused.
        drive(1'b1, 17'h0BEEF, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_d !== 17'h1AAAA || bif.chn_b_in_prdy !== 1'b0) begin
            $display("FAIL bp_hold: got d=%h prdy=%b expected d=1aaaa prdy=0",
                     bif.chn_b_rsci_d, bif.chn_b_in_prdy);
            n_fail++;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b1 || bif.chn_b_rsci_d !== 17'h05555 ||
            bif.chn_b_in_prdy !== 1'b1) begin
            $display("FAIL bp_release: got vd=%b d=%h prdy=%b expected vd=1 d=05555 prdy=1",
                     bif.chn_b_rsci_vd, bif.chn_b_rsci_d, bif.chn_b_in_prdy);
            n_fail++;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0) begin
            $display("FAIL bp_drain: got vd=%b expected 0 (refused word leaked)", bif.chn_b_rsci_vd);
            n_fail++;
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_push_pop();
        drive(1'b1, 17'h00123, 1'b0, 1'b0);
        step();
        drive(1'b1, 17'h00456, 1'b1, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b1 || bif.chn_b_rsci_d !== 17'h00456 ||
            bif.chn_b_in_prdy !== 1'b1) begin
            $display("FAIL pushpop: got vd=%b d=%h prdy=%b expected vd=1 d=00456 prdy=1",
                     bif.chn_b_rsci_vd, bif.chn_b_rsci_d, bif.chn_b_in_prdy);
            n_fail++;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0) begin
            $display("FAIL pushpop_noskid: got vd=%b expected 0", bif.chn_b_rsci_vd); n_fail++;
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        drive(1'b1, 17'h00111, 1'b0, 1'b0);
        step();
        drive(1'b1, 17'h00222, 1'b0, 1'b0);
        step();
        drive(1'b1, 17'h1DEAD, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0 || bif.chn_b_in_prdy !== 1'b1) begin
            $display("FAIL clr_full: got vd=%b prdy=%b expected vd=0 prdy=1",
                     bif.chn_b_rsci_vd, bif.chn_b_in_prdy);
            n_fail++;
        end
        // clr at count 1 with a real push (prdy=1) must also discard it.
        drive(1'b1, 17'h00333, 1'b0, 1'b0);
        step();
        drive(1'b1, 17'h1BEEF, 1'b1, 1'b1);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bif.chn_b_rsci_vd !== 1'b0 || bif.chn_b_in_prdy !== 1'b1) begin
                $display("FAIL clr_discard_%0d: got vd=%b d=%h prdy=%b expected vd=0 prdy=1",
                         k, bif.chn_b_rsci_vd, bif.chn_b_rsci_d, bif.chn_b_in_prdy);
                n_fail++;
            end
            step();
        end
        drive(1'b1, 17'h00777, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b1 || bif.chn_b_rsci_d !== 17'h00777) begin
            $display("FAIL clr_refill: got vd=%b d=%h expected vd=1 d=00777",
                     bif.chn_b_rsci_vd, bif.chn_b_rsci_d);
            n_fail++;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 17'h00999, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        nvdla_core_rstn = 1'b0;
        #1;
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0 || bif.chn_b_in_prdy !== 1'b0 ||
            bif.chn_b_rsci_d !== 17'h00000) begin
            $display("FAIL async_reset: got vd=%b prdy=%b d=%h expected vd=0 prdy=0 d=00000",
                     bif.chn_b_rsci_vd, bif.chn_b_in_prdy, bif.chn_b_rsci_d);
            n_fail++;
        end
        step();
        nvdla_core_rstn = 1'b1;
        step();
        n_cmp++;
        if (bif.chn_b_rsci_vd !== 1'b0 || bif.chn_b_in_prdy !== 1'b1) begin
            $display("FAIL post_reset: got vd=%b prdy=%b expected vd=0 prdy=1",
                     bif.chn_b_rsci_vd, bif.chn_b_in_prdy);
            n_fail++;
        end
    endtask

`ifdef HLS_FP17_ADD_CHN_B_BP_CNT_EN
    task automatic test_bp_cnt();
        drive(1'b1, 17'h00042, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step();
        n_cmp++;
        if (bif.chn_b_bp_cnt !== 16'd5) begin
            $display("FAIL bp_cnt_5: got %h expected 0005", bif.chn_b_bp_cnt); n_fail++;
        end
        for (int k = 0; k < 70000; k++) step();
        n_cmp++;
        if (bif.chn_b_bp_cnt !== 16'hFFFF) begin
            $display("FAIL bp_cnt_sat: got %h expected ffff", bif.chn_b_bp_cnt); n_fail++;
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (bif.chn_b_bp_cnt !== 16'h0000 || bif.chn_b_rsci_vd !== 1'b0) begin
            $display("FAIL bp_cnt_clr: got cnt=%h vd=%b expected cnt=0000 vd=0",
                     bif.chn_b_bp_cnt, bif.chn_b_rsci_vd);
            n_fail++;
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_push_pop();
        test_clear();
        test_mid_reset();
`ifdef HLS_FP17_ADD_CHN_B_BP_CNT_EN
        test_bp_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
